// File: rtl/asym_bram_fwd_if.sv
// ---------------------------------------------------------------------------
// asym_bram_fwd_if
// Groups the write port, the read port and the status outputs of the
// asymmetric RAM.
//   master : drives WEN/WADDR/WDATA and REN/RADDR, observes RDATA/RVALID/READY
//   slave  : the RAM side
// ---------------------------------------------------------------------------
interface asym_bram_fwd_if #(
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 128,
    parameter int WADDR_WIDTH = 10,
    parameter int RADDR_WIDTH = 8
);
    logic                   WEN;
    logic [WADDR_WIDTH-1:0] WADDR;
    logic [WDATA_WIDTH-1:0] WDATA;
    logic                   REN;
    logic [RADDR_WIDTH-1:0] RADDR;
    logic [RDATA_WIDTH-1:0] RDATA;
    logic                   RVALID;
    logic                   READY;

    modport master (
        output WEN, WADDR, WDATA, REN, RADDR,
        input  RDATA, RVALID, READY
    );

    modport slave (
        input  WEN, WADDR, WDATA, REN, RADDR,
        output RDATA, RVALID, READY
    );
endinterface

// File: rtl/asym_bram_fwd.sv
// ---------------------------------------------------------------------------
// asym_bram_fwd
// Asymmetric simple-dual-port RAM: one write port and one read port of
// different widths (either may be the wide one). Optional second read
// register, optional same-cycle write-to-read forwarding, read-valid strobe
// and optional zero-fill sweep after reset.
//
// Ports
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : asym_bram_fwd_if.slave (WEN/WADDR/WDATA, REN/RADDR,
//            RDATA/RVALID/READY)
//
// FSM states
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_INIT | zero-fill sweep, one narrow word per cycle, ports ignored
//   ST_RUN  | READY=1, writes and reads accepted every cycle
//
// Storage is split into RATIO banks of narrow words; narrow index n lives in
// bank n % RATIO at row n / RATIO, so a wide access touches every bank once
// and a narrow access touches one bank. Each bank has one write per cycle.
// ---------------------------------------------------------------------------
module asym_bram_fwd #(
    parameter int WDATA_WIDTH = 32,
    parameter int RDATA_WIDTH = 128,
    parameter int WADDR_WIDTH = 10,
    parameter int RADDR_WIDTH = 8,
    parameter int MEMSIZE     = 1024,
    parameter int PIPELINED   = 0,
    parameter int FORWARDING  = 0,
    parameter int INIT_ZERO   = 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    asym_bram_fwd_if.slave bus
);

    localparam int MINW     = (WDATA_WIDTH < RDATA_WIDTH) ? WDATA_WIDTH : RDATA_WIDTH;
    localparam int MAXW     = (WDATA_WIDTH < RDATA_WIDTH) ? RDATA_WIDTH : WDATA_WIDTH;
    localparam int RATIO    = MAXW / MINW;
    localparam int WR_RATIO = WDATA_WIDTH / MINW;
    localparam int RD_RATIO = RDATA_WIDTH / MINW;
    localparam int DEPTH    = (MEMSIZE + RATIO - 1) / RATIO;
    localparam int RW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW       = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MW-1:0]          r_sweep;
    logic [MW-1:0]          w_sweep_nxt;
    logic                   w_ready;
    logic                   w_wr_en;
    logic                   w_rd_en;

    int                     w_wr_n [WR_RATIO];
    int                     w_rd_n [RD_RATIO];

    logic [RATIO-1:0]       w_bk_we;
    logic [RW-1:0]          w_bk_wrow [RATIO];
    logic [MINW-1:0]        w_bk_wd   [RATIO];
    logic [RW-1:0]          w_bk_rrow [RATIO];
    logic [MINW-1:0]        w_bk_q    [RATIO];

    logic [RDATA_WIDTH-1:0] w_rd_word;
    logic [RDATA_WIDTH-1:0] r_s1_data;
    logic                   r_s1_vld;

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_ready     = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_sweep == MW'(MEMSIZE - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep + MW'(1);
                end
            end
            ST_RUN:  w_ready = 1'b1;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_wr_en   = w_ready & bus.WEN;
    assign w_rd_en   = w_ready & bus.REN;
    assign bus.READY = w_ready;

    // Narrow index of every lane on each port.
    always_comb begin
        for (int i = 0; i < WR_RATIO; i++) w_wr_n[i] = int'(bus.WADDR) * WR_RATIO + i;
        for (int j = 0; j < RD_RATIO; j++) w_rd_n[j] = int'(bus.RADDR) * RD_RATIO + j;
    end

    // ---------------- bank write steering ----------------
    always_comb begin
        for (int b = 0; b < RATIO; b++) begin
            w_bk_we[b]   = 1'b0;
            w_bk_wrow[b] = '0;
            w_bk_wd[b]   = '0;
        end
        if (r_state == ST_INIT) begin
            for (int b = 0; b < RATIO; b++) begin
                if (int'(r_sweep) % RATIO == b) begin
                    w_bk_we[b]   = 1'b1;
                    w_bk_wrow[b] = RW'(int'(r_sweep) / RATIO);
                end
            end
        end else if (w_wr_en) begin
            // lanes beyond MEMSIZE are silently dropped
            for (int i = 0; i < WR_RATIO; i++) begin
                for (int b = 0; b < RATIO; b++) begin
                    if (w_wr_n[i] < MEMSIZE && w_wr_n[i] % RATIO == b) begin
                        w_bk_we[b]   = 1'b1;
                        w_bk_wrow[b] = RW'(w_wr_n[i] / RATIO);
                        w_bk_wd[b]   = bus.WDATA[i*MINW +: MINW];
                    end
                end
            end
        end
    end

    // ---------------- bank read row select ----------------
    always_comb begin
        for (int b = 0; b < RATIO; b++) w_bk_rrow[b] = '0;
        for (int j = 0; j < RD_RATIO; j++) begin
            for (int b = 0; b < RATIO; b++) begin
                if (w_rd_n[j] < MEMSIZE && w_rd_n[j] % RATIO == b)
                    w_bk_rrow[b] = RW'(w_rd_n[j] / RATIO);
            end
        end
    end

    for (genvar gb = 0; gb < RATIO; gb++) begin : g_bank
        logic [MINW-1:0] r_mem [DEPTH];

        always_ff @(posedge CLK) begin
            if (w_bk_we[gb]) r_mem[w_bk_wrow[gb]] <= w_bk_wd[gb];
        end

        // Reading the array before this edge's write gives read-first data.
        assign w_bk_q[gb] = r_mem[w_bk_rrow[gb]];
    end

    // ---------------- read word assembly ----------------
    // Out-of-range lanes read 0 even when a write targets them.
    always_comb begin
        w_rd_word = '0;
        for (int j = 0; j < RD_RATIO; j++) begin
            if (w_rd_n[j] < MEMSIZE) begin
                if (FORWARDING != 0 && w_wr_en && (w_rd_n[j] / WR_RATIO == int'(bus.WADDR))) begin
                    for (int i = 0; i < WR_RATIO; i++) begin
                        if (w_rd_n[j] % WR_RATIO == i)
                            w_rd_word[j*MINW +: MINW] = bus.WDATA[i*MINW +: MINW];
                    end
                end else begin
                    for (int b = 0; b < RATIO; b++) begin
                        if (w_rd_n[j] % RATIO == b)
                            w_rd_word[j*MINW +: MINW] = w_bk_q[b];
                    end
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_rd_en;
            if (w_rd_en) r_s1_data <= w_rd_word;
        end
    end

    if (PIPELINED != 0) begin : g_pipe
        logic [RDATA_WIDTH-1:0] r_s2_data;
        logic                   r_s2_vld;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_s2_vld  <= 1'b0;
                r_s2_data <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) r_s2_data <= r_s1_data;
            end
        end

        assign bus.RDATA  = r_s2_data;
        assign bus.RVALID = r_s2_vld;
    end else begin : g_nopipe
        assign bus.RDATA  = r_s1_data;
        assign bus.RVALID = r_s1_vld;
    end

endmodule

// File: tb/tb_asym_bram_fwd.sv
// ---------------------------------------------------------------------------
// tb_asym_bram_fwd
// Two instances share clock and reset:
//   A : W=32  R=128, MEMSIZE=1000, latency 1, write-first forwarding
//   B : W=128 R=32,  MEMSIZE=1024, latency 2, read-first
// Directed vectors with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_asym_bram_fwd;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;

    asym_bram_fwd_if #(.WDATA_WIDTH(32),  .RDATA_WIDTH(128), .WADDR_WIDTH(10), .RADDR_WIDTH(8))  bus_a ();
    asym_bram_fwd_if #(.WDATA_WIDTH(128), .RDATA_WIDTH(32),  .WADDR_WIDTH(8),  .RADDR_WIDTH(10)) bus_b ();

    asym_bram_fwd #(
        .WDATA_WIDTH(32), .RDATA_WIDTH(128), .WADDR_WIDTH(10), .RADDR_WIDTH(8),
        .MEMSIZE(1000), .PIPELINED(0), .FORWARDING(1), .INIT_ZERO(1)
    ) u_dut_a (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus_a)
    );

    asym_bram_fwd #(
        .WDATA_WIDTH(128), .RDATA_WIDTH(32), .WADDR_WIDTH(8), .RADDR_WIDTH(10),
        .MEMSIZE(1024), .PIPELINED(1), .FORWARDING(0), .INIT_ZERO(1)
    ) u_dut_b (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds REN high on both ports through the sweep; counts cycles to READY
    // and any RVALID seen before READY.
    task automatic run_sweep(output int ca, output int cb, output int rva, output int rvb);
        bit da;
        bit db;
        da = 1'b0; db = 1'b0;
        ca = -1;   cb = -1;
        rva = 0;   rvb = 0;
        bus_a.REN = 1'b1; bus_a.RADDR = 8'd1;
        bus_b.REN = 1'b1; bus_b.RADDR = 10'd9;
        for (int c = 1; c <= 3000 && !(da && db); c++) begin
            step();
            if (!da) begin
                rva += int'(bus_a.RVALID);
                if (bus_a.READY) begin da = 1'b1; ca = c; bus_a.REN = 1'b0; end
            end
            if (!db) begin
                rvb += int'(bus_b.RVALID);
                if (bus_b.READY) begin db = 1'b1; cb = c; bus_b.REN = 1'b0; end
            end
        end
        bus_a.REN = 1'b0;
        bus_b.REN = 1'b0;
    endtask

    initial begin : main
        int ca, cb, rva, rvb;
        int bad_a, bad_b, rv_a, rv_b;

        n_vec = 0;
        n_mis = 0;
        rst_n = 1'b0;
        bus_a.WEN = 1'b0; bus_a.WADDR = '0; bus_a.WDATA = '0; bus_a.REN = 1'b0; bus_a.RADDR = '0;
        bus_b.WEN = 1'b0; bus_b.WADDR = '0; bus_b.WDATA = '0; bus_b.REN = 1'b0; bus_b.RADDR = '0;

        // ---------------- reset state ----------------
        repeat (3) step();
        chk("rst_ready_a",  bus_a.READY,  0);
        chk("rst_ready_b",  bus_b.READY,  0);
        chk("rst_rvalid_a", bus_a.RVALID, 0);
        chk("rst_rdata_a",  bus_a.RDATA,  0);
        chk("rst_rdata_b",  bus_b.RDATA,  0);

        rst_n = 1'b1;
        run_sweep(ca, cb, rva, rvb);
        chk("sweep_len_a",   ca,  1000);
        chk("sweep_len_b",   cb,  1024);
        chk("init_rvalid_a", rva, 0);
        chk("init_rvalid_b", rvb, 0);

        // ---------------- every address reads zero ----------------
        bad_a = 0; bad_b = 0; rv_a = 0; rv_b = 0;
        for (int i = 0; i < 1027; i++) begin
            bus_a.REN   = (i < 256);
            bus_a.RADDR = 8'(i);
            bus_b.REN   = (i < 1024);
            bus_b.RADDR = 10'(i);
            step();
            rv_a += int'(bus_a.RVALID);
            rv_b += int'(bus_b.RVALID);
            if (bus_a.RVALID && bus_a.RDATA !== 128'h0) bad_a++;
            if (bus_b.RVALID && bus_b.RDATA !== 32'h0)  bad_b++;
        end
        chk("zero_rd_cnt_a", rv_a,  256);
        chk("zero_rd_cnt_b", rv_b,  1024);
        chk("zero_rd_bad_a", bad_a, 0);
        chk("zero_rd_bad_b", bad_b, 0);

        // ---------------- A: same-cycle write-first forwarding ----------------
        bus_a.WEN = 1'b1; bus_a.WADDR = 10'd5; bus_a.WDATA = 32'hCAFEF00D;
        bus_a.REN = 1'b1; bus_a.RADDR = 8'd1;
        step();
        chk("a_fwd_data", bus_a.RDATA,  128'h00000000_00000000_CAFEF00D_00000000);
        chk("a_fwd_rv",   bus_a.RVALID, 1);
        bus_a.WEN = 1'b0;
        step();
        chk("a_after_fwd", bus_a.RDATA, 128'h00000000_00000000_CAFEF00D_00000000);

        // ---------------- A: narrow writes, one wide read ----------------
        bus_a.REN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_a.WEN = 1'b1; bus_a.WADDR = 10'(4 + k); bus_a.WDATA = 32'h11111111 * (k + 1);
            step();
        end
        bus_a.WEN = 1'b0;
        chk("a_wr_norv", bus_a.RVALID, 0);
        chk("a_hold",    bus_a.RDATA,  128'h00000000_00000000_CAFEF00D_00000000);
        bus_a.REN = 1'b1; bus_a.RADDR = 8'd1;
        step();
        bus_a.REN = 1'b0;
        chk("a_wide_rd", bus_a.RDATA,  128'h44444444_33333333_22222222_11111111);
        chk("a_wide_rv", bus_a.RVALID, 1);
        step();
        chk("a_rv_strobe", bus_a.RVALID, 0);
        chk("a_rd_hold",   bus_a.RDATA,  128'h44444444_33333333_22222222_11111111);

        // one lane forwarded, the other three from memory
        bus_a.WEN = 1'b1; bus_a.WADDR = 10'd6; bus_a.WDATA = 32'h5A5A5A5A;
        bus_a.REN = 1'b1; bus_a.RADDR = 8'd1;
        step();
        chk("a_part_fwd", bus_a.RDATA, 128'h44444444_5A5A5A5A_22222222_11111111);

        // ---------------- A: MEMSIZE=1000 boundary ----------------
        bus_a.WADDR = 10'd999; bus_a.WDATA = 32'h99999999; bus_a.REN = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            bus_a.WADDR = 10'(1000 + k); bus_a.WDATA = 32'hDEADBEEF;
            bus_a.REN = 1'b1; bus_a.RADDR = 8'd250;
            step();
            if (k == 1) chk("a_oob_fwd", bus_a.RDATA, 0);
        end
        bus_a.WEN = 1'b0; bus_a.RADDR = 8'd250;
        step();
        chk("a_oob_rd", bus_a.RDATA, 0);
        bus_a.RADDR = 8'd249;
        step();
        chk("a_last_word", bus_a.RDATA, 128'h99999999_00000000_00000000_00000000);
        bus_a.RADDR = 8'd0;
        step();
        bus_a.REN = 1'b0;
        chk("a_no_alias", bus_a.RDATA, 0);

        // ---------------- B: read-first collision ----------------
        bus_b.WEN = 1'b1; bus_b.WADDR = 8'd1; bus_b.WDATA = 128'h00000000_00000000_CAFEF00D_00000000;
        bus_b.REN = 1'b1; bus_b.RADDR = 10'd5;
        step();
        bus_b.WEN = 1'b0;
        step();
        bus_b.REN = 1'b0;
        chk("b_rdfirst",    bus_b.RDATA,  0);
        chk("b_rdfirst_rv", bus_b.RVALID, 1);
        step();
        chk("b_after_wr", bus_b.RDATA,  32'hCAFEF00D);
        chk("b_after_rv", bus_b.RVALID, 1);
        step();
        chk("b_rv_idle", bus_b.RVALID, 0);

        // ---------------- B: wide write, four narrow reads ----------------
        bus_b.WEN = 1'b1; bus_b.WADDR = 8'd2; bus_b.WDATA = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        step();
        bus_b.WEN = 1'b0;
        bus_b.REN = 1'b1; bus_b.RADDR = 10'd8;
        step();
        chk("b_lat2_rv", bus_b.RVALID, 0);
        bus_b.RADDR = 10'd9;
        step();
        chk("b_lane0", bus_b.RDATA, 32'hAAAAAAAA);
        chk("b_rv0",   bus_b.RVALID, 1);
        bus_b.RADDR = 10'd10;
        step();
        chk("b_lane1", bus_b.RDATA, 32'hBBBBBBBB);
        chk("b_rv1",   bus_b.RVALID, 1);
        bus_b.RADDR = 10'd11;
        step();
        chk("b_lane2", bus_b.RDATA, 32'hCCCCCCCC);
        chk("b_rv2",   bus_b.RVALID, 1);
        bus_b.REN = 1'b0;
        step();
        chk("b_lane3", bus_b.RDATA, 32'hDDDDDDDD);
        chk("b_rv3",   bus_b.RVALID, 1);
        step();
        chk("b_rv_end", bus_b.RVALID, 0);
        chk("b_hold",   bus_b.RDATA,  32'hDDDDDDDD);

        // ---------------- reset with a read in flight, then mid-sweep ----------------
        bus_b.REN = 1'b1; bus_b.RADDR = 10'd9;
        step();
        bus_b.REN = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_fly_rv_b",   bus_b.RVALID, 0);
        chk("rst_fly_data_b", bus_b.RDATA,  0);
        chk("rst_fly_rdy_a",  bus_a.READY,  0);
        step();
        chk("rst_fly_rv_b2", bus_b.RVALID, 0);
        rst_n = 1'b1;
        repeat (300) step();
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_sweep(ca, cb, rva, rvb);
        chk("resweep_len_a", ca,  1000);
        chk("resweep_len_b", cb,  1024);
        chk("resweep_rv_a",  rva, 0);
        chk("resweep_rv_b",  rvb, 0);

        // sweep cleared earlier contents
        bus_a.REN = 1'b1; bus_a.RADDR = 8'd1;
        bus_b.REN = 1'b1; bus_b.RADDR = 10'd9;
        step();
        bus_a.REN = 1'b0;
        bus_b.REN = 1'b0;
        chk("cleared_a", bus_a.RDATA, 0);
        chk("cleared_rv_a", bus_a.RVALID, 1);
        step();
        chk("cleared_b", bus_b.RDATA, 0);
        chk("cleared_rv_b", bus_b.RVALID, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/asym_bram_fwd.md
# asym_bram_fwd

Parametrised asymmetric simple-dual-port RAM: one write port and one read port of different widths, with either port the wide one. Adds an optional second read pipeline stage, same-cycle write-to-read forwarding, a read-valid strobe and an optional post-reset zero-fill sweep. It is the width-converting table store for match-action lookup and packet-buffer staging, sitting between BSV-generated control logic and the Xilinx BRAM primitives.

## Interface
- WDATA_WIDTH, 32, write data width (bits)
- RDATA_WIDTH, 128, read data width; max(W,R)/min(W,R) = RATIO, a power of two ≥1
- WADDR_WIDTH, 10, write address width
- RADDR_WIDTH, 8, read address width; narrow-port address width = wide-port address width + log2(RATIO)
- MEMSIZE, 1024, depth in narrow words (minWIDTH each)
- PIPELINED, 0, 0: read latency 1; 1: read latency 2 (extra output register)
- FORWARDING, 0, 1: same-cycle write data forwarded to read (write-first); 0: read-first
- INIT_ZERO, 1, 1: zero-fill all MEMSIZE words after reset; 0: no sweep
- CLK  input  1  clock, all logic on rising edge
- RST_N  input  1  asynchronous, active-low reset
- WEN  input  1  write enable
- WADDR  input  WADDR_WIDTH  write address (in WDATA_WIDTH units)
- WDATA  input  WDATA_WIDTH  write data
- REN  input  1  read enable
- RADDR  input  RADDR_WIDTH  read address (in RDATA_WIDTH units)
- RDATA  output  RDATA_WIDTH  read data
- RVALID  output  1  one-cycle strobe: RDATA carries a requested read
- READY  output  1  high when ports are accepted

## Operation
- Storage: MEMSIZE narrow words, index n; lane i of a wide word at wide address A is narrow index {A, i}, occupying bits [(i+1)·minWIDTH-1 : i·minWIDTH].
- Wide write: all RATIO lanes written in one cycle. Wide read: all lanes read in one cycle. RATIO=1 degenerates to a plain RAM.
- Narrow index ≥ MEMSIZE: write lane dropped; read lane returns 0.
- States: INIT (sweep) and RUN. Reset → INIT if INIT_ZERO=1, else RUN.
- INIT: counter writes 0 to narrow index 0,1,…,MEMSIZE-1, one per cycle; READY=0; WEN/REN ignored (no write, no RVALID). After writing MEMSIZE-1 → RUN next cycle.
- RUN: READY=1; WEN and REN honoured every cycle, independently.
- Collision (WEN and REN same cycle, overlapping narrow indices): FORWARDING=1 → overlapping lanes return WDATA lanes, others return memory; FORWARDING=0 → all lanes return pre-write contents. Write then read in later cycle always returns new data.
- RDATA holds its last value when no read completes.

## Timing
- Reset (RST_N low, asynchronous): RDATA=0, RVALID=0, in-flight reads discarded, sweep counter=0, READY=0 if INIT_ZERO=1 else 1. Memory contents not reset except by sweep.
- Reset deasserted at cycle 0: READY rises at cycle MEMSIZE (INIT_ZERO=1).
- Reset asserted mid-sweep: sweep restarts from index 0.
- Read at cycle t: PIPELINED=0 → RDATA/RVALID at t+1; PIPELINED=1 → t+2. Back-to-back reads give back-to-back RVALID; pipeline never stalls.
- Write at cycle t visible to reads issued at t+1 (or at t with FORWARDING=1).

## Test plan
- Reset, INIT_ZERO=1, MEMSIZE=1024 → READY low 1024 cycles then high; wide read of every address returns 0; REN during INIT produces no RVALID.
- W=32, R=128: write 0x11111111…0x44444444 to WADDR 4..7, REN RADDR=1 → RDATA=0x44444444_33333333_22222222_11111111 at t+1 (t+2 with PIPELINED=1), RVALID one cycle.
- W=128, R=32: write 0xDDDD_CCCC_BBBB_AAAA-style word at WADDR=2, read RADDR 8..11 back-to-back → lanes in order, four consecutive RVALIDs.
- Same-cycle write WADDR=5 data 0xCAFEF00D over old 0x0 with read RADDR=1: FORWARDING=1 → lane 1 = 0xCAFEF00D, FORWARDING=0 → lane 1 = 0x0; read next cycle → 0xCAFEF00D both.
- MEMSIZE=1000, read RADDR=250 (indices 1000–1003) → RDATA=0; write there is dropped.
- RST_N pulsed low mid-sweep and with read in flight → RVALID stays 0, RDATA=0, sweep restarts, READY rises MEMSIZE cycles after release.
